// File: rtl/pio_bidir_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pio_bidir_ext_pkg
// Purpose  : Shared constants for the bidirectional parallel I/O port.
//            - Avalon word addresses of the eight registers.
//            - Edge-capture mode encodings.
// Revision : 1.0  initial release
// ============================================================================
package pio_bidir_ext_pkg;

  typedef logic [2:0] addr_t;

  localparam addr_t ADDR_DATA     = 3'd0;
  localparam addr_t ADDR_DIR      = 3'd1;
  localparam addr_t ADDR_IRQ_MASK = 3'd2;
  localparam addr_t ADDR_EDGE_CAP = 3'd3;
  localparam addr_t ADDR_OUTSET   = 3'd4;
  localparam addr_t ADDR_OUTCLR   = 3'd5;
  localparam addr_t ADDR_OD       = 3'd6;
  localparam addr_t ADDR_INFO     = 3'd7;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage
`default_nettype wire

// File: rtl/pio_bidir_ext_if.sv
`default_nettype none
// ============================================================================
// Module   : pio_bidir_ext_if
// Purpose  : Avalon-MM slave bus bundle for pio_bidir_ext.
// Signals  : address[2:0], chipselect, write_n, writedata[31:0] (to slave)
//            readdata[31:0], irq                                (from slave)
// Revision : 1.0  initial release
// ============================================================================
interface pio_bidir_ext_if;
  import pio_bidir_ext_pkg::*;

  addr_t       address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface
`default_nettype wire

// File: rtl/pio_sync_bits.sv
`default_nettype none
// ============================================================================
// Module   : pio_sync_bits
// Purpose  : Multi-stage synchroniser for WIDTH asynchronous inputs. Every
//            flop resets to 0.
// Ports    : clk, reset_n (async, active-low)
//            async_in[WIDTH-1:0]  raw pin values
//            sync_out[WIDTH-1:0]  values after STAGES flops
// Revision : 1.0  initial release
// ============================================================================
module pio_sync_bits #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [STAGES-1:0][WIDTH-1:0] chain_q;
  logic [STAGES-1:0][WIDTH-1:0] chain_d;

  // Stage 0 takes the pin; each later stage takes its predecessor.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], async_in};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign sync_out = chain_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pio_bidir_ext.sv
`default_nettype none
// ============================================================================
// Module   : pio_bidir_ext
// Purpose  : Avalon-MM bidirectional parallel I/O with per-bit direction,
//            open-drain mode, atomic set/clear, synchronised inputs and
//            edge capture with a maskable level interrupt.
// Ports    : clk, reset_n (async, active-low)
//            bus         Avalon-MM slave (address/chipselect/write_n/
//                        writedata in, readdata/irq out)
//            bidir_port  WIDTH tri-state pins
// Revision : 1.0  initial release
// ============================================================================
module pio_bidir_ext
  import pio_bidir_ext_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 2,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  pio_bidir_ext_if.slave    bus,
  inout  wire  [WIDTH-1:0]  bidir_port
);

  // The edge detector stays blind until the synchroniser and prev_in have
  // been refilled with real pin values, so idle-high pins do not look like
  // rising edges coming out of reset.
  localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q,      dir_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] od_q,       od_d;
  logic [WIDTH-1:0] prev_in_q,  prev_in_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [2:0]       prime_q,    prime_d;

  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] drive_en;
  logic [WIDTH-1:0] drive_val;
  logic             wr;
  logic             prime_done;

  pio_sync_bits #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (bidir_port),
    .sync_out (sync_in)
  );

  if (WIDTH < 32) begin : g_unused_wd
    logic unused_wd;
    assign unused_wd = ^bus.writedata[31:WIDTH];
  end

  always_comb begin
    wr         = bus.chipselect && !bus.write_n;
    wdata      = bus.writedata[WIDTH-1:0];
    prime_done = (prime_q == PRIME_DONE);

    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_mask_d = irq_mask_q;
    od_d       = od_q;
    w1c        = '0;

    if (wr) begin
      case (bus.address)
        ADDR_DATA:     data_out_d = wdata;
        ADDR_DIR:      dir_d      = wdata;
        ADDR_IRQ_MASK: irq_mask_d = wdata;
        ADDR_EDGE_CAP: w1c        = wdata;
        ADDR_OUTSET:   data_out_d = data_out_q | wdata;
        ADDR_OUTCLR:   data_out_d = data_out_q & ~wdata;
        ADDR_OD:       od_d       = wdata;
        default:       ;
      endcase
    end

    rise = sync_in & ~prev_in_q;
    fall = ~sync_in & prev_in_q;
    if (!prime_done) begin
      edge_det = '0;
    end else if (EDGE_TYPE == EDGE_RISING) begin
      edge_det = rise;
    end else if (EDGE_TYPE == EDGE_FALLING) begin
      edge_det = fall;
    end else begin
      edge_det = rise | fall;
    end

    // A fresh edge overrides a simultaneous write-1-to-clear.
    edge_cap_d = (edge_cap_q & ~w1c) | edge_det;
    prev_in_d  = sync_in;
    prime_d    = prime_done ? prime_q : prime_q + 3'd1;

    readdata_d = '0;
    case (bus.address)
      ADDR_DATA:     readdata_d[WIDTH-1:0] = sync_in;
      ADDR_DIR:      readdata_d[WIDTH-1:0] = dir_q;
      ADDR_IRQ_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE_CAP: readdata_d[WIDTH-1:0] = edge_cap_q;
      ADDR_OD:       readdata_d[WIDTH-1:0] = od_q;
      ADDR_INFO: begin
        readdata_d[5:0] = 6'(WIDTH);
        readdata_d[9:8] = 2'(EDGE_TYPE);
      end
      default:       ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_OUT;
      dir_q      <= RESET_DIR;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      od_q       <= '0;
      prev_in_q  <= '0;
      readdata_q <= '0;
      prime_q    <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      od_q       <= od_d;
      prev_in_q  <= prev_in_d;
      readdata_q <= readdata_d;
      prime_q    <= prime_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = |(edge_cap_q & irq_mask_q);

  // Open-drain bits only ever pull low; a 1 releases the pin.
  assign drive_en  = dir_q & ~(od_q & data_out_q);
  assign drive_val = data_out_q & ~od_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = drive_en[i] ? drive_val[i] : 1'bz;
  end

endmodule
`default_nettype wire

// File: tb/tb_pio_bidir_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_pio_bidir_ext
// Purpose  : Self-checking bench for pio_bidir_ext (WIDTH=8, SYNC_STAGES=2,
//            rising-edge capture, RESET_OUT=8'hA5, RESET_DIR=8'h0F). Pins
//            carry pull-ups and an optional bench-side driver.
// Revision : 1.0  initial release
// ============================================================================
module tb_pio_bidir_ext;
  import pio_bidir_ext_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] drv_en;
  logic [7:0] drv_val;
  wire  [7:0] pins;
  int         checks   = 0;
  int         failures = 0;
  logic [31:0] rd;

  pio_bidir_ext_if bus ();

  pio_bidir_ext #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .EDGE_TYPE   (0),
    .RESET_OUT   (8'hA5),
    .RESET_DIR   (8'h0F)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .bidir_port (pins)
  );

  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup (pins[i]);
    assign pins[i] = drv_en[i] ? drv_val[i] : 1'bz;
  end

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          wr;
    addr_t       addr;
    logic [31:0] data;
    int          waitc;
    logic [31:0] exp_rd;
    bit          chk_pins;
    logic [7:0]  exp_pins;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input string n, input bit w, input addr_t a,
                              input logic [31:0] d, input int wc,
                              input logic [31:0] e, input bit cp,
                              input logic [7:0] ep);
    vec_t v;
    v.name = n; v.wr = w; v.addr = a; v.data = d; v.waitc = wc;
    v.exp_rd = e; v.chk_pins = cp; v.exp_pins = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input addr_t a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input addr_t a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    @(negedge clk);
    d = bus.readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    drv_en         = 8'h00;
    drv_val        = 8'h00;
    bus.address    = ADDR_DATA;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;

    // ---- reset state ----
    idle(3);
    check("reset_pins", {24'h0, pins}, 32'h0000_00F5);
    check("reset_irq", {31'h0, bus.irq}, 32'h0);
    check("reset_readdata", bus.readdata, 32'h0);
    reset_n = 1'b1;
    idle(8);

    // ---- table-driven register / pin vectors ----
    vt.push_back(mk("rst_dir",      0, ADDR_DIR,      0, 0, 32'h0F,  0, 0));
    vt.push_back(mk("rst_data",     0, ADDR_DATA,     0, 0, 32'hF5,  0, 0));
    vt.push_back(mk("rst_mask",     0, ADDR_IRQ_MASK, 0, 0, 32'h00,  0, 0));
    vt.push_back(mk("rst_edgecap",  0, ADDR_EDGE_CAP, 0, 0, 32'h00,  0, 0));
    vt.push_back(mk("rst_od",       0, ADDR_OD,       0, 0, 32'h00,  0, 0));
    vt.push_back(mk("rd_outset",    0, ADDR_OUTSET,   0, 0, 32'h00,  0, 0));
    vt.push_back(mk("rd_info",      0, ADDR_INFO,     0, 0, 32'h008, 0, 0));
    vt.push_back(mk("wr_info",      1, ADDR_INFO, 32'hFFFF_FFFF, 0, 0, 0, 0));
    vt.push_back(mk("info_ro",      0, ADDR_INFO,     0, 0, 32'h008, 0, 0));
    vt.push_back(mk("dir_after_info",0, ADDR_DIR,     0, 0, 32'h0F,  0, 0));
    vt.push_back(mk("wr_dir_ff",    1, ADDR_DIR, 32'hFFFF_FFFF, 0, 0, 1, 8'hA5));
    vt.push_back(mk("rd_dir_ff",    0, ADDR_DIR,      0, 0, 32'hFF,  0, 0));
    vt.push_back(mk("wr_data_3c",   1, ADDR_DATA, 32'h3C, 0, 0, 1, 8'h3C));
    vt.push_back(mk("rd_data_3c",   0, ADDR_DATA,     0, 2, 32'h3C,  0, 0));
    vt.push_back(mk("wr_data_0f",   1, ADDR_DATA, 32'h0F, 0, 0, 1, 8'h0F));
    vt.push_back(mk("outset_f0",    1, ADDR_OUTSET, 32'hF0, 0, 0, 1, 8'hFF));
    vt.push_back(mk("outclr_0f",    1, ADDR_OUTCLR, 32'h0F, 0, 0, 1, 8'hF0));
    vt.push_back(mk("outset_00",    1, ADDR_OUTSET, 32'h00, 0, 0, 1, 8'hF0));
    vt.push_back(mk("rd_outclr",    0, ADDR_OUTCLR,   0, 0, 32'h00,  0, 0));
    vt.push_back(mk("rd_data_f0",   0, ADDR_DATA,     0, 2, 32'hF0,  0, 0));
    vt.push_back(mk("dir_01",       1, ADDR_DIR,  32'h01, 0, 0, 1, 8'hFE));
    vt.push_back(mk("od_01_low",    1, ADDR_OD,   32'h01, 0, 0, 1, 8'hFE));
    vt.push_back(mk("rd_od",        0, ADDR_OD,       0, 0, 32'h01,  0, 0));
    vt.push_back(mk("od_release",   1, ADDR_DATA, 32'h01, 0, 0, 1, 8'hFF));
    vt.push_back(mk("rd_od_pullup", 0, ADDR_DATA,     0, 2, 32'hFF,  0, 0));

    foreach (vt[i]) begin
      if (vt[i].wr) begin
        bus_write(vt[i].addr, vt[i].data);
        if (vt[i].chk_pins)
          check(vt[i].name, {24'h0, pins}, {24'h0, vt[i].exp_pins});
      end else begin
        idle(vt[i].waitc);
        bus_read(vt[i].addr, rd);
        check(vt[i].name, rd, vt[i].exp_rd);
      end
    end
    check("table_irq", {31'h0, bus.irq}, 32'h0);

    // ---- open-drain bit released, bench pulls it low ----
    drv_en  = 8'h01;
    drv_val = 8'h00;
    idle(1);
    check("od_ext_low_pins", {24'h0, pins}, 32'hFE);
    idle(2);
    bus_read(ADDR_DATA, rd);
    check("od_ext_low_read", rd, 32'hFE);
    drv_en = 8'h00;

    // ---- input latency: pin change before edge k shows at edge k+2 ----
    bus_write(ADDR_OD, 32'h0);
    bus_write(ADDR_DIR, 32'h0);
    drv_en  = 8'hFF;
    drv_val = 8'h00;
    idle(4);
    @(negedge clk);
    bus.address = ADDR_DATA;
    drv_val = 8'h5A;
    @(negedge clk); check("data_lat_k",   bus.readdata, 32'h00);
    @(negedge clk); check("data_lat_k1",  bus.readdata, 32'h00);
    @(negedge clk); check("data_lat_k2",  bus.readdata, 32'h5A);

    // ---- edge capture and interrupt ----
    drv_val = 8'h00;
    idle(4);
    bus_write(ADDR_EDGE_CAP, 32'hFF);
    bus_read(ADDR_EDGE_CAP, rd);
    check("edgecap_cleared", rd, 32'h00);
    bus_write(ADDR_IRQ_MASK, 32'h02);
    bus_read(ADDR_IRQ_MASK, rd);
    check("rd_mask", rd, 32'h02);

    @(negedge clk);
    drv_val[1] = 1'b1;
    @(negedge clk); check("irq_k",  {31'h0, bus.irq}, 32'h0);
    @(negedge clk); check("irq_k1", {31'h0, bus.irq}, 32'h0);
    @(negedge clk); check("irq_k2", {31'h0, bus.irq}, 32'h1);
    bus_read(ADDR_EDGE_CAP, rd);
    check("edgecap_rise", rd, 32'h02);
    bus_read(ADDR_EDGE_CAP, rd);
    check("edgecap_read_no_side_effect", rd, 32'h02);

    bus_write(ADDR_EDGE_CAP, 32'h02);
    check("irq_after_w1c", {31'h0, bus.irq}, 32'h0);
    bus_read(ADDR_EDGE_CAP, rd);
    check("edgecap_after_w1c", rd, 32'h00);

    drv_val[1] = 1'b0;
    idle(5);
    check("fall_no_irq", {31'h0, bus.irq}, 32'h0);
    bus_read(ADDR_EDGE_CAP, rd);
    check("fall_no_cap", rd, 32'h00);

    drv_val[2] = 1'b1;
    idle(5);
    check("masked_no_irq", {31'h0, bus.irq}, 32'h0);
    bus_read(ADDR_EDGE_CAP, rd);
    check("masked_cap", rd, 32'h04);
    bus_write(ADDR_EDGE_CAP, 32'h04);
    bus_read(ADDR_EDGE_CAP, rd);
    check("masked_cleared", rd, 32'h00);

    // ---- collision: W1C of bit 1 sampled on the edge that sets it ----
    @(negedge clk);
    drv_val[1] = 1'b1;
    @(negedge clk);
    bus_write(ADDR_EDGE_CAP, 32'h02);
    check("collision_irq", {31'h0, bus.irq}, 32'h1);
    bus_read(ADDR_EDGE_CAP, rd);
    check("collision_cap", rd, 32'h02);

    // ---- asynchronous reset mid-operation ----
    drv_en = 8'h00;
    bus_write(ADDR_DIR, 32'hFF);
    bus_write(ADDR_DATA, 32'h3C);
    check("prereset_pins", {24'h0, pins}, 32'h3C);
    @(negedge clk);
    bus.address = ADDR_INFO;
    @(negedge clk);
    check("prereset_info", bus.readdata, 32'h008);
    check("prereset_irq", {31'h0, bus.irq}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_pins", {24'h0, pins}, 32'hF5);
    check("midreset_irq", {31'h0, bus.irq}, 32'h0);
    check("midreset_readdata", bus.readdata, 32'h0);
    idle(2);
    reset_n = 1'b1;
    idle(8);
    bus_read(ADDR_EDGE_CAP, rd);
    check("primed_no_edge", rd, 32'h00);
    bus_read(ADDR_DIR, rd);
    check("postreset_dir", rd, 32'h0F);
    bus_read(ADDR_DATA, rd);
    check("postreset_data", rd, 32'hF5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
